// File: rtl/mul_unit_pkg.sv
// mul_unit_pkg: shared multiply-operation encodings used by the decoder, the multiplier and the result mux
package mul_unit_pkg;
    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_sel_e;
endpackage

// File: rtl/mul_unit_if.sv
// mul_unit_if: request/result bundle between the execute stage and the multiplier
interface mul_unit_if #(
    parameter int N = 32
) ();
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [1:0]   MulSel;
    logic         busy;
    logic         done;
    logic [N-1:0] MulRes;

    modport master (output start, A, B, MulSel, input busy, done, MulRes);
    modport slave  (input start, A, B, MulSel, output busy, done, MulRes);
endinterface

// File: rtl/mul_unit.sv
// mul_unit: iterative radix-2 shift-add multiplier for mul/mulh/mulhsu/mulhu, N+2 cycles per operation
module mul_unit
    import mul_unit_pkg::*;
#(
    parameter int N = 32
) (
    input logic       clk,
    input logic       rst,
    mul_unit_if.slave m
);
    localparam int CW = $clog2(N) + 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic           neg_q, neg_d;
    mul_sel_e       sel_q, sel_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [N-1:0]   res_q, res_d;
    logic           sa, sb;
    logic [N:0]     sum;
    logic [2*N-1:0] prod;

    // capture magnitudes and sign in IDLE, one shift-add step per RUN cycle, sign fix and result select in FIX
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        sel_d    = sel_q;
        res_d    = res_q;
        done_d   = 1'b0;
        sa       = m.A[N-1] & (m.MulSel == MULH || m.MulSel == MULHSU);
        sb       = m.B[N-1] & (m.MulSel == MULH);
        sum      = {1'b0, acc_q[2*N-1:N]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        prod     = neg_q ? -acc_q : acc_q;
        case (state_q)
            IDLE: if (m.start) begin
                state_d  = RUN;
                cnt_d    = '0;
                mcand_d  = sa ? -m.A : m.A;
                mplier_d = sb ? -m.B : m.B;
                acc_d    = '0;
                neg_d    = sa ^ sb;
                sel_d    = mul_sel_e'(m.MulSel);
            end
            RUN: begin
                acc_d    = {sum, acc_q[N-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                state_d  = (cnt_q == CW'(N - 1)) ? FIX : RUN;
            end
            FIX: begin
                res_d   = (sel_q == MUL) ? prod[N-1:0] : prod[2*N-1:N];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    // register all state and outputs; reset discards any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            sel_q    <= MUL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            res_q    <= res_d;
        end
    end

    assign m.busy   = busy_q;
    assign m.done   = done_q;
    assign m.MulRes = res_q;
endmodule
